ps2_rx_sequencer: RTL

//  Synchronous PS/2 host-side receive controller. Samples raw keyboard clock/data in the

---
 rtl/ps2_rx_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_sequencer.sv
// ps2_rx_sequencer
//   Host-side PS/2 receive controller. Synchronizes the raw keyboard clock/data
//   into the clk domain and captures 11-bit frames (start, 8 data LSB-first, odd
//   parity, stop). E0/F0 prefix bytes are folded into a single key event, which
//   is presented through a one-entry valid/ready buffer. While an event is held
//   and no frame is in flight, the keyboard clock is inhibited.
//
// Ports
//   clk          in   system clock, all logic on posedge
//   reset        in   asynchronous active-low reset
//   keyb_clk_in  in   raw PS/2 clock (asynchronous)
//   keyb_data    in   raw PS/2 data (asynchronous)
//   keyb_clk_oe  out  1 = pull PS/2 clock low (inhibit)
//   key_code     out  scan code of the event, prefixes stripped
//   key_release  out  event was preceded by F0
//   key_ext      out  event was preceded by E0
//   key_valid    out  event available, held until accepted
//   key_ready    in   consumer accepts on key_valid & key_ready
//   frame_err    out  one-cycle pulse on bad start/parity/stop or timeout
//   overflow     out  sticky: an event was dropped because the buffer was full
//   ovf_clear    in   clears overflow, wins over a same-cycle set
module ps2_rx_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyb_clk_in,
    input  logic       keyb_data,
    output logic       keyb_clk_oe,
    output logic [7:0] key_code,
    output logic       key_release,
    output logic       key_ext,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       frame_err,
    output logic       overflow,
    input  logic       ovf_clear
);

    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);
    localparam logic [ToW-1:0] ToOne  = ToW'(1);

    typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

    state_e         state_q, state_d;
    logic           clk_s1_q, clk_s2_q, clk_prev_q;
    logic           data_s1_q, data_s2_q;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [9:0]     shift_q, shift_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           ext_q, ext_d, brk_q, brk_d;
    logic [7:0]     code_q, code_d;
    logic           rel_out_q, rel_out_d, ext_out_q, ext_out_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic           ovf_q, ovf_d;
    logic           oe_q, oe_d;
    logic           ps2_fall, emit, load;

    // Synchronizers idle high so reset never looks like a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            clk_s1_q   <= keyb_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= keyb_data;
            data_s2_q  <= data_s1_q;
        end
    end

    assign ps2_fall = clk_prev_q & ~clk_s2_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        to_cnt_d  = '0;
        ext_d     = ext_q;
        brk_d     = brk_q;
        err_d     = 1'b0;
        emit      = 1'b0;
        case (state_q)
            StIdle: begin
                // A falling edge with data high is a stray edge, not a start bit.
                if (ps2_fall && !data_s2_q) begin
                    state_d   = StShift;
                    bit_cnt_d = 4'd1;
                end
            end
            StShift: begin
                if (ps2_fall) begin
                    shift_d   = {data_s2_q, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd10) begin
                        state_d = StCheck;
                    end
                end else if (to_cnt_q == ToLast) begin
                    err_d   = 1'b1;
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                    state_d = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + ToOne;
                end
            end
            StCheck: begin
                state_d = StIdle;
                // shift_q = {stop, parity, data[7:0]}
                if (!(^shift_q[8:0]) || !shift_q[9]) begin
                    err_d = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else if (shift_q[7:0] == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (shift_q[7:0] == 8'hF0) begin
                    brk_d = 1'b1;
                end else begin
                    emit  = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // One-entry output buffer; a slot freed by a same-cycle accept can be refilled.
    always_comb begin
        load      = emit & (~valid_q | key_ready);
        valid_d   = load | (valid_q & ~key_ready);
        code_d    = load ? shift_q[7:0] : code_q;
        rel_out_d = load ? brk_q : rel_out_q;
        ext_out_d = load ? ext_q : ext_out_q;
        ovf_d     = ovf_clear ? 1'b0 : (ovf_q | (emit & valid_q & ~key_ready));
        oe_d      = (state_q == StIdle) & valid_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            to_cnt_q  <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            code_q    <= '0;
            rel_out_q <= 1'b0;
            ext_out_q <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            to_cnt_q  <= to_cnt_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            code_q    <= code_d;
            rel_out_q <= rel_out_d;
            ext_out_q <= ext_out_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            oe_q      <= oe_d;
        end
    end

    assign keyb_clk_oe = oe_q;
    assign key_code    = code_q;
    assign key_release = rel_out_q;
    assign key_ext     = ext_out_q;
    assign key_valid   = valid_q;
    assign frame_err   = err_q;
    assign overflow    = ovf_q;

endmodule
